// File: rtl/maj_tree_pkg.sv
// Shared types and helpers for the majority-cell AND/OR reduction tree.
package maj_tree_pkg;

  typedef enum logic {
    MODE_AND = 1'b0,
    MODE_OR  = 1'b1
  } mode_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Neutral element of the reduction: 1 for AND, 0 for OR.
  function automatic logic identity(input mode_e mode);
    return (mode == MODE_AND);
  endfunction

  function automatic int padded_width(input int n);
    return 1 << $clog2(n);
  endfunction

endpackage

// File: rtl/maj_tree_eval_if.sv
// Config port, input and output handshake bundle for maj_tree_eval.
// Defining MAJ_TREE_INVERT_EN adds the cfg_inv signal.
interface maj_tree_eval_if #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 6
);
  import maj_tree_pkg::*;

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [N_IN-1:0]  cfg_mask;
  mode_e            cfg_mode;
`ifdef MAJ_TREE_INVERT_EN
  logic             cfg_inv;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;

  modport master (
    output cfg_we, cfg_idx, cfg_mask, cfg_mode,
`ifdef MAJ_TREE_INVERT_EN
    output cfg_inv,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_mask, cfg_mode,
`ifdef MAJ_TREE_INVERT_EN
    input  cfg_inv,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/maj_tree_eval_lane.sv
// One output channel: identity substitution, padding and a registered MAJ3 tree.
// With MAJ_TREE_INVERT_EN the final level is XORed with a per-vector invert bit.
module maj_tree_lane
  import maj_tree_pkg::*;
#(
  parameter int N_IN = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_IN-1:0] in_data,
  input  logic [N_IN-1:0] mask,
  input  mode_e           mode,
`ifdef MAJ_TREE_INVERT_EN
  input  logic            inv,
`endif
  output logic            result
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int PW     = padded_width(N_IN);
  localparam int TW     = 2 * PW - 1;

  // All tree levels live in one flat vector; level s starts at stage_off(s).
  function automatic int stage_off(input int s);
    return 2 * PW - 2 * (PW >> s);
  endfunction

  logic [PW-1:0] data_ext;
  logic [PW-1:0] mask_ext;
  logic [TW-1:0] tree_d;
  logic [TW-1:0] tree_q;
  mode_e         mode_d [LEVELS];
  mode_e         mode_q [LEVELS];
`ifdef MAJ_TREE_INVERT_EN
  logic [LEVELS-1:0] inv_d;
  logic [LEVELS-1:0] inv_q;
`endif

  assign data_ext = PW'(in_data);
  assign mask_ext = PW'(mask);

  always_comb begin
    mode_d = mode_q;
    mode_d[0] = mode;
    for (int l = 1; l < LEVELS; l++) begin
      mode_d[l] = mode_q[l-1];
    end
  end

`ifdef MAJ_TREE_INVERT_EN
  always_comb begin
    inv_d = inv_q;
    inv_d[0] = inv;
    for (int l = 1; l < LEVELS; l++) begin
      inv_d[l] = inv_q[l-1];
    end
  end
`endif

  // Each level reduces the previous registered level using the mode that travelled with it.
  always_comb begin
    tree_d = tree_q;
    for (int i = 0; i < PW; i++) begin
      tree_d[i] = mask_ext[i] ? data_ext[i] : identity(mode);
    end
    for (int s = 1; s <= LEVELS; s++) begin
      for (int j = 0; j < (PW >> s); j++) begin
        tree_d[stage_off(s) + j] = maj3(tree_q[stage_off(s-1) + 2*j],
                                        tree_q[stage_off(s-1) + 2*j + 1],
                                        mode_q[s-1]);
      end
    end
`ifdef MAJ_TREE_INVERT_EN
    tree_d[TW-1] = tree_d[TW-1] ^ inv_q[LEVELS-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree_q <= '0;
      mode_q <= '{default: MODE_AND};
`ifdef MAJ_TREE_INVERT_EN
      inv_q  <= '0;
`endif
    end else if (en) begin
      tree_q <= tree_d;
      mode_q <= mode_d;
`ifdef MAJ_TREE_INVERT_EN
      inv_q  <= inv_d;
`endif
    end
  end

  assign result = tree_q[TW-1];

endmodule

// File: rtl/maj_tree_eval.sv
// Pipelined AND/OR evaluator built from MAJ3 cells: N_OUT configurable lanes
// sharing one valid pipeline. MAJ_TREE_INVERT_EN adds per-channel output inversion.
module maj_tree_eval
  import maj_tree_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int N_OUT = 6
) (
  input logic            clk,
  input logic            rst,
  maj_tree_eval_if.slave bus
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [N_IN-1:0]  mask_d [N_OUT];
  logic [N_IN-1:0]  mask_q [N_OUT];
  mode_e            mode_d [N_OUT];
  mode_e            mode_q [N_OUT];
`ifdef MAJ_TREE_INVERT_EN
  logic [N_OUT-1:0] inv_d;
  logic [N_OUT-1:0] inv_q;
`endif
  logic [LEVELS:0]  valid_d;
  logic [LEVELS:0]  valid_q;
  logic             stall;
  logic             en;
  logic             accept;
  logic [N_OUT-1:0] lane_result;

  assign stall        = valid_q[LEVELS] && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = !rst && !stall;
  assign accept       = bus.in_valid && bus.in_ready;

  // Writes to out-of-range channel indices match no channel and are dropped.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
`ifdef MAJ_TREE_INVERT_EN
    inv_d  = inv_q;
`endif
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(k))) begin
        mask_d[k] = bus.cfg_mask;
        mode_d[k] = bus.cfg_mode;
`ifdef MAJ_TREE_INVERT_EN
        inv_d[k]  = bus.cfg_inv;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '{default: '0};
      mode_q <= '{default: MODE_AND};
`ifdef MAJ_TREE_INVERT_EN
      inv_q  <= '0;
`endif
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
`ifdef MAJ_TREE_INVERT_EN
      inv_q  <= inv_d;
`endif
    end
  end

  always_comb begin
    valid_d = {valid_q[LEVELS-1:0], accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    maj_tree_lane #(
      .N_IN(N_IN)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .in_data (bus.in_data),
      .mask    (mask_q[k]),
      .mode    (mode_q[k]),
`ifdef MAJ_TREE_INVERT_EN
      .inv     (inv_q[k]),
`endif
      .result  (lane_result[k])
    );
  end

  assign bus.out_valid = valid_q[LEVELS];
  assign bus.out_data  = lane_result;

endmodule
